// File: rtl/map_ss_seq_pkg.sv
// Shared types and defaults for the mapper save-state sequencer.
package map_ss_seq_pkg;

    localparam int unsigned SS_LEN_DEF     = 128;
    localparam int unsigned STROBE_LEN_DEF = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_ADDR = 3'd1,
        S_CAP  = 3'd2,
        L_RD   = 3'd3,
        L_WAIT = 3'd4,
        L_STB  = 3'd5,
        FIN    = 3'd6
    } ss_state_e;

endpackage

// File: rtl/map_ss_seq_if.sv
// Sequencer bus: request/status, mapper save-state port and buffer memory port.
// SS_CHKSUM_EN adds the chksum signal.
interface map_ss_seq_if;

    logic       start_save;
    logic       start_load;
    logic       busy;
    logic       done;
    logic       ss_act;
    logic       ss_we;
    logic [7:0] ss_addr;
    logic [7:0] ss_wdat;
    logic [7:0] ss_rdat;
    logic [7:0] mem_addr;
    logic       mem_re;
    logic       mem_we;
    logic [7:0] mem_wdat;
    logic [7:0] mem_rdat;
`ifdef SS_CHKSUM_EN
    logic [7:0] chksum;

    modport master (
        input  start_save, start_load, ss_rdat, mem_rdat,
        output busy, done, ss_act, ss_we, ss_addr, ss_wdat,
               mem_addr, mem_re, mem_we, mem_wdat, chksum
    );
    modport slave (
        output start_save, start_load, ss_rdat, mem_rdat,
        input  busy, done, ss_act, ss_we, ss_addr, ss_wdat,
               mem_addr, mem_re, mem_we, mem_wdat, chksum
    );
`else
    modport master (
        input  start_save, start_load, ss_rdat, mem_rdat,
        output busy, done, ss_act, ss_we, ss_addr, ss_wdat,
               mem_addr, mem_re, mem_we, mem_wdat
    );
    modport slave (
        output start_save, start_load, ss_rdat, mem_rdat,
        input  busy, done, ss_act, ss_we, ss_addr, ss_wdat,
               mem_addr, mem_re, mem_we, mem_wdat
    );
`endif

endinterface

// File: rtl/map_ss_seq_strobe.sv
// Write-strobe timer: after a load pulse, active is high for exactly STROBE_LEN
// cycles and last marks the final one. Both outputs are registered.
module map_ss_strobe #(
    parameter int unsigned STROBE_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic active,
    output logic last
);

    // cnt holds the number of active cycles remaining after the current one
    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            active <= 1'b0;
            last   <= 1'b0;
        end else if (load) begin
            cnt    <= 4'(STROBE_LEN - 1);
            active <= 1'b1;
            last   <= (STROBE_LEN == 1);
        end else if (active) begin
            if (last) begin
                active <= 1'b0;
                last   <= 1'b0;
            end else begin
                cnt  <= cnt - 4'd1;
                last <= (cnt == 4'd1);
            end
        end
    end

endmodule

// File: rtl/map_ss_seq.sv
// Mapper save-state sequencer: copies SS_LEN mapper registers to the buffer memory
// (save) or back (load). Define SS_CHKSUM_EN to add the transfer checksum output.
module map_ss_seq
    import map_ss_seq_pkg::*;
#(
    parameter int unsigned SS_LEN     = SS_LEN_DEF,
    parameter int unsigned STROBE_LEN = STROBE_LEN_DEF
) (
    input  logic         clk,
    input  logic         map_rst,
    map_ss_seq_if.master bus
);

    localparam logic [7:0] LAST_IDX = 8'(SS_LEN - 1);

    ss_state_e  state;
    logic [7:0] idx;
    logic       busy, done, ss_act, mem_re, mem_we;
    logic [7:0] ss_wdat, mem_wdat;
    logic       stb_active, stb_last;

    map_ss_strobe #(.STROBE_LEN(STROBE_LEN)) u_strobe (
        .clk    (clk),
        .rst    (map_rst),
        .load   (state == L_WAIT),
        .active (stb_active),
        .last   (stb_last)
    );

    // Outputs are set on the edge entering the state they belong to, so they are
    // registered yet line up with the state.
    always_ff @(posedge clk) begin
        if (map_rst) begin
            state    <= IDLE;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ss_act   <= 1'b0;
            ss_wdat  <= '0;
            mem_re   <= 1'b0;
            mem_we   <= 1'b0;
            mem_wdat <= '0;
        end else begin
            done   <= 1'b0;
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    idx <= '0;
                    if (bus.start_save) begin
                        state  <= S_ADDR;
                        busy   <= 1'b1;
                        ss_act <= 1'b1;
                    end else if (bus.start_load) begin
                        state  <= L_RD;
                        busy   <= 1'b1;
                        mem_re <= 1'b1;
                    end
                end
                S_ADDR: begin
                    // ss_addr is already idx here, so ss_rdat is the byte to store
                    state    <= S_CAP;
                    mem_we   <= 1'b1;
                    mem_wdat <= bus.ss_rdat;
                end
                S_CAP: begin
                    if (idx == LAST_IDX) begin
                        state  <= FIN;
                        ss_act <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        idx   <= idx + 8'd1;
                        state <= S_ADDR;
                    end
                end
                L_RD: state <= L_WAIT;
                L_WAIT: begin
                    ss_wdat <= bus.mem_rdat;
                    ss_act  <= 1'b1;
                    state   <= L_STB;
                end
                L_STB: begin
                    if (stb_last) begin
                        ss_act <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            idx    <= idx + 8'd1;
                            state  <= L_RD;
                            mem_re <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.ss_act   = ss_act;
    assign bus.ss_we    = stb_active;
    assign bus.ss_wdat  = ss_wdat;
    assign bus.mem_re   = mem_re;
    assign bus.mem_we   = mem_we;
    assign bus.mem_wdat = mem_wdat;
    assign bus.ss_addr  = (state inside {S_ADDR, S_CAP, L_STB}) ? idx : '0;
    assign bus.mem_addr = (state inside {S_CAP, L_RD}) ? idx : '0;

`ifdef SS_CHKSUM_EN
    logic [7:0] chksum;
    logic       stb_first;

    always_ff @(posedge clk) begin
        if (map_rst) begin
            chksum    <= '0;
            stb_first <= 1'b0;
        end else begin
            stb_first <= (state == L_WAIT);
            if (state == IDLE && (bus.start_save || bus.start_load)) begin
                chksum <= '0;
            end else if (state == S_CAP) begin
                chksum <= chksum + bus.ss_rdat;
            end else if (stb_first) begin
                chksum <= chksum + ss_wdat;
            end
        end
    end

    assign bus.chksum = chksum;
`endif

endmodule

// File: tb/tb_map_ss_seq.sv
// Directed bench for map_ss_seq: save, load, start arbitration, reset abort,
// SS_LEN=256 terminal index and (with SS_CHKSUM_EN) the checksum.
module tb_map_ss_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic map_rst;
    logic rdat_one;
    logic img_mode;
    int unsigned ncmp = 0;
    int unsigned nfail = 0;

    map_ss_seq_if bus ();
    map_ss_seq_if bus2 ();

    logic [7:0] mem [256];

    map_ss_seq #(.SS_LEN(128), .STROBE_LEN(4)) u_dut (
        .clk     (clk),
        .map_rst (map_rst),
        .bus     (bus.master)
    );

    map_ss_seq #(.SS_LEN(256), .STROBE_LEN(4)) u_dut256 (
        .clk     (clk),
        .map_rst (map_rst),
        .bus     (bus2.master)
    );

    // mapper models: combinational read data from ss_addr
    assign bus.ss_rdat   = rdat_one ? 8'h01 : (bus.ss_addr ^ 8'h5A);
    assign bus2.ss_rdat  = bus2.ss_addr ^ 8'h5A;
    assign bus2.mem_rdat = 8'h00;

    // buffer memory model: one-cycle read latency; img_mode serves mem[i]=255-i
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdat;
        if (bus.mem_re) bus.mem_rdat <= img_mode ? (8'd255 - bus.mem_addr) : mem[bus.mem_addr];
    end

    int unsigned done_cnt, done_cyc, we_cnt, re_cnt, busy_bad, both_bad, wdat_bad, act_bad;
    int unsigned stb_cnt [256];
    logic [7:0]  chk_at_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Steps ncyc cycles from cycle 1 (first cycle after the start edge), sampling on negedge.
    task automatic run(input int unsigned ncyc, input int unsigned load_at, input int unsigned busy_hi);
        done_cnt = 0; done_cyc = 0; we_cnt = 0; re_cnt = 0;
        busy_bad = 0; both_bad = 0; wdat_bad = 0; act_bad = 0; chk_at_done = '0;
        for (int i = 0; i < 256; i++) stb_cnt[i] = 0;
        for (int unsigned c = 1; c <= ncyc; c++) begin
            if (bus.done) begin
                done_cnt++;
                done_cyc = c;
`ifdef SS_CHKSUM_EN
                chk_at_done = bus.chksum;
`endif
            end
            if ((c <= busy_hi && !bus.busy) || (c > busy_hi + 1 && bus.busy)) busy_bad++;
            if (bus.mem_we) we_cnt++;
            if (bus.mem_re) re_cnt++;
            if (bus.mem_we && bus.ss_we) both_bad++;
            if (bus.mem_re && bus.ss_act) act_bad++;
            if (bus.ss_we) begin
                stb_cnt[bus.ss_addr]++;
                if (bus.ss_wdat !== (8'd255 - bus.ss_addr) || !bus.ss_act) wdat_bad++;
            end
            bus.start_load = (load_at != 0 && c == load_at);
            @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},     32'(bus.busy),     32'd0);
        check({tag, "_done"},     32'(bus.done),     32'd0);
        check({tag, "_ss_act"},   32'(bus.ss_act),   32'd0);
        check({tag, "_ss_we"},    32'(bus.ss_we),    32'd0);
        check({tag, "_ss_addr"},  32'(bus.ss_addr),  32'd0);
        check({tag, "_ss_wdat"},  32'(bus.ss_wdat),  32'd0);
        check({tag, "_mem_re"},   32'(bus.mem_re),   32'd0);
        check({tag, "_mem_we"},   32'(bus.mem_we),   32'd0);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        check({tag, "_mem_wdat"}, 32'(bus.mem_wdat), 32'd0);
    endtask

    int unsigned n_bad, w256, z256, d256_cnt, d256_cyc;
    logic [7:0]  last256;

    initial begin
        map_rst = 1'b1; rdat_one = 1'b0; img_mode = 1'b0;
        bus.start_save = 1'b0; bus.start_load = 1'b0;
        bus2.start_save = 1'b0; bus2.start_load = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        check("rst_busy256", 32'(bus2.busy), 32'd0);
        map_rst = 1'b0;
        @(negedge clk);

        // save: rdat = addr ^ 5A; the XOR permutes 0..127 so the sum is 8128 mod 256 = C0
        bus.start_save = 1'b1; @(negedge clk); bus.start_save = 1'b0;
        run(300, 0, 256);
        check("save_writes",   we_cnt,   32'd128);
        check("save_done_cyc", done_cyc, 32'd257);
        check("save_done_cnt", done_cnt, 32'd1);
        check("save_busy",     busy_bad, 32'd0);
        check("save_we_excl",  both_bad, 32'd0);
        n_bad = 0;
        for (int i = 0; i < 128; i++) begin
            logic [7:0] ev;
            ev = 8'(i) ^ 8'h5A;
            if (mem[i] !== ev) n_bad++;
        end
        check("save_mem", n_bad, 32'd0);
`ifdef SS_CHKSUM_EN
        check("save_chksum", 32'(chk_at_done), 32'hC0);
`endif

        // load: mem[i] = 255-i, 4-cycle strobes, done at 6*128+1; sum = 24512 mod 256 = C0
        img_mode = 1'b1;
        bus.start_load = 1'b1; @(negedge clk); bus.start_load = 1'b0;
        run(800, 0, 768);
        check("load_done_cyc", done_cyc, 32'd769);
        check("load_done_cnt", done_cnt, 32'd1);
        check("load_busy",     busy_bad, 32'd0);
        check("load_wdat",     wdat_bad, 32'd0);
        check("load_act_rel",  act_bad,  32'd0);
        check("load_we_excl",  both_bad, 32'd0);
        n_bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (stb_cnt[i] != ((i < 128) ? 4 : 0)) n_bad++;
        end
        check("load_stb_len", n_bad, 32'd0);
`ifdef SS_CHKSUM_EN
        check("load_chksum", 32'(chk_at_done), 32'hC0);
`endif

        // both starts together: save wins; start_load at cycle 50 ignored
        img_mode = 1'b0;
        bus.start_save = 1'b1; bus.start_load = 1'b1; @(negedge clk);
        bus.start_save = 1'b0; bus.start_load = 1'b0;
        run(900, 50, 256);
        check("both_writes",   we_cnt,   32'd128);
        check("both_reads",    re_cnt,   32'd0);
        check("both_done_cnt", done_cnt, 32'd1);
        check("both_done_cyc", done_cyc, 32'd257);

        // reset during save byte 10 (its S_ADDR is cycle 21), with a coincident start_load
        bus.start_save = 1'b1; @(negedge clk); bus.start_save = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_addr", 32'(bus.ss_addr), 32'd10);
        map_rst = 1'b1; bus.start_load = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        map_rst = 1'b0; bus.start_load = 1'b0;
        @(negedge clk);
        check("abort_start_ign", 32'(bus.busy), 32'd0);
        check("abort_no_done",   32'(bus.done), 32'd0);
        img_mode = 1'b1;
        bus.start_load = 1'b1; @(negedge clk); bus.start_load = 1'b0;
        run(800, 0, 768);
        check("reload_done_cyc", done_cyc, 32'd769);
        check("reload_done_cnt", done_cnt, 32'd1);
        check("reload_wdat",     wdat_bad, 32'd0);

        // SS_LEN=256: idx must stop at 255 without wrapping
        bus2.start_save = 1'b1; @(negedge clk); bus2.start_save = 1'b0;
        w256 = 0; z256 = 0; d256_cnt = 0; d256_cyc = 0; last256 = '0;
        for (int unsigned c = 1; c <= 600; c++) begin
            if (bus2.mem_we) begin
                w256++;
                last256 = bus2.mem_addr;
                if (bus2.mem_addr == 8'd0) z256++;
            end
            if (bus2.done) begin
                d256_cnt++;
                d256_cyc = c;
            end
            @(negedge clk);
        end
        check("s256_writes",   w256,          32'd256);
        check("s256_last",     32'(last256),  32'd255);
        check("s256_addr0",    z256,          32'd1);
        check("s256_done_cnt", d256_cnt,      32'd1);
        check("s256_done_cyc", d256_cyc,      32'd513);

`ifdef SS_CHKSUM_EN
        // 128 bytes of 1 sum to 8'h80
        rdat_one = 1'b1;
        bus.start_save = 1'b1; @(negedge clk); bus.start_save = 1'b0;
        run(300, 0, 256);
        check("ones_done_cyc", done_cyc, 32'd257);
        check("ones_chksum",   32'(chk_at_done), 32'h80);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
